// File: rtl/ni_packetizer_pkg.sv
// Shared definitions for the NI transmit packetizer:
// flit type codes, header LEN field position, FSM states.
package ni_packetizer_pkg;

    localparam int NI_DATA_W  = 32;
    localparam int NI_MAX_LEN = 15;
    localparam int NI_CNT_W   = 16;

    localparam int HDR_LEN_LSB = 16;
    localparam int HDR_LEN_MSB = 23;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_TAIL     = 2'b01,
        FT_HEAD     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_HDR = 1'b0,
        ST_PAY = 1'b1
    } state_e;

endpackage

// File: rtl/ni_packetizer_skid.sv
// Two-entry register FIFO holding classified flits;
// entry 0 is always the head presented to the router.
module ni_packetizer_skid #(
    parameter int W = 34
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [1:0]   o_occ,
    output logic [W-1:0] o_head,
    output logic         o_valid
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_occ;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_occ <= 2'd0;
        end else begin
            unique case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_e0 <= i_push_data;
                    else               r_e1 <= i_push_data;
                    if (r_occ != 2'd2) r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new word lands behind the survivor
                    if (r_occ == 2'd2) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_push_data;
                    end else begin
                        r_e0 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_head  = r_e0;
    assign o_valid = (r_occ != 2'd0);

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit stage: pops gp_fifo words, parses headers and
// emits typed flits to the router over valid/ready.
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int DATA_W  = NI_DATA_W,
    parameter int MAX_LEN = NI_MAX_LEN,
    parameter int CNT_W   = NI_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_data,
    output logic              o_fifo_rd_en,
    output logic [DATA_W+1:0] o_flit_out,
    output logic              o_flit_valid,
    input  logic              i_flit_ready,
    output logic              o_busy,
    output logic              o_len_err,
    output logic [CNT_W-1:0]  o_pkt_count
);

    localparam int FLIT_W = DATA_W + 2;

    state_e           r_state;
    state_e           w_state_nx;
    logic [7:0]       r_rem;
    logic [7:0]       w_rem_nx;
    logic             r_inflight;
    logic             r_len_err;
    logic [CNT_W-1:0] r_pkt_cnt;

    logic             w_pop;
    logic             w_push;
    logic             w_len_err;
    flit_type_e       w_type;
    logic [1:0]       w_occ;
    logic [2:0]       w_cred;
    logic [7:0]       w_len;
    logic             w_rd_en;

    assign w_pop  = o_flit_valid & i_flit_ready;
    assign w_len  = i_fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];

    // slots already claimed once this cycle's pop retires
    assign w_cred = {1'b0, w_occ} + {2'b00, r_inflight}
                  - {2'b00, w_pop};
    assign w_rd_en = !i_fifo_empty && !i_reset
                  && (w_cred < 3'd2);

    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_rem;
        w_push     = 1'b0;
        w_type     = FT_BODY;
        w_len_err  = 1'b0;
        if (r_inflight) begin
            unique case (r_state)
                ST_HDR: begin
                    if (w_len == 8'd0) begin
                        w_push = 1'b1;
                        w_type = FT_HEADTAIL;
                    end else if (w_len <= 8'(MAX_LEN)) begin
                        w_push     = 1'b1;
                        w_type     = FT_HEAD;
                        w_rem_nx   = w_len;
                        w_state_nx = ST_PAY;
                    end else begin
                        w_len_err = 1'b1;
                    end
                end
                ST_PAY: begin
                    w_push = 1'b1;
                    if (r_rem > 8'd1) begin
                        w_type   = FT_BODY;
                        w_rem_nx = r_rem - 8'd1;
                    end else begin
                        w_type     = FT_TAIL;
                        w_state_nx = ST_HDR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_HDR;
            r_rem      <= 8'd0;
            r_inflight <= 1'b0;
            r_len_err  <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_rem      <= w_rem_nx;
            r_inflight <= w_rd_en;
            r_len_err  <= w_len_err;
            if (w_pop && o_flit_out[DATA_W])
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    ni_packetizer_skid #(
        .W(FLIT_W)
    ) u_skid (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data ({w_type, i_fifo_data}),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (o_flit_out),
        .o_valid     (o_flit_valid)
    );

    assign o_fifo_rd_en = w_rd_en;
    assign o_len_err    = r_len_err;
    assign o_pkt_count  = r_pkt_cnt;
    assign o_busy       = (r_state == ST_PAY) | r_inflight
                        | (w_occ != 2'd0);

endmodule
